// File: rtl/maxmin_pkg.sv
// Shared types for the maxmin_stream block: FSM state encoding and count-width helper.
package maxmin_pkg;

  typedef enum logic {
    StAccum,
    StHold
  } state_e;

  function automatic int unsigned calc_cw(input int unsigned frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/maxmin_cmp.sv
// Combinational WIDTH-bit comparator, unsigned or two's-complement by SIGNED.
module maxmin_cmp #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt
);

  if (SIGNED) begin : g_signed
    assign gt = $signed(a) > $signed(b);
    assign lt = $signed(a) < $signed(b);
  end else begin : g_unsigned
    assign gt = a > b;
    assign lt = a < b;
  end

endmodule

// File: rtl/maxmin_stream.sv
// Per-frame running max/min over a valid/ready sample stream.
// Define MAXMIN_INDEX_EN to add out_max_idx/out_min_idx (0-based extremum positions).
module maxmin_stream
  import maxmin_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 16,
  parameter bit          SIGNED    = 1'b0,
  localparam int unsigned CW       = calc_cw(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CW-1:0]    out_count
`ifdef MAXMIN_INDEX_EN
  ,
  output logic [CW-1:0]    out_max_idx,
  output logic [CW-1:0]    out_min_idx
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic [CW-1:0]    count_q, count_d;
  logic             accept, first, gt_max, lt_min;
  logic             lt_max, gt_min;
  logic             unused_cmp;

  maxmin_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp_max (
    .a  (in_data),
    .b  (max_q),
    .gt (gt_max),
    .lt (lt_max)
  );

  maxmin_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp_min (
    .a  (in_data),
    .b  (min_q),
    .gt (gt_min),
    .lt (lt_min)
  );

  assign unused_cmp = lt_max ^ gt_min;

  assign accept = in_valid && (state_q == StAccum);
  assign first  = (count_q == '0);

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    count_d = count_q;
    unique case (state_q)
      StAccum: begin
        if (in_valid) begin
          count_d = count_q + CW'(1);
          if (first) begin
            max_d = in_data;
            min_d = in_data;
          end else begin
            // Strict compares: ties keep the earlier sample.
            if (gt_max) max_d = in_data;
            if (lt_min) min_d = in_data;
          end
          if (in_last || (count_d == CW'(FRAME_LEN))) state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StAccum;
          count_d = '0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
      max_q   <= '0;
      min_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StHold);
  assign out_max   = max_q;
  assign out_min   = min_q;
  assign out_count = count_q;

`ifdef MAXMIN_INDEX_EN
  logic [CW-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;

  always_comb begin
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    if (accept) begin
      if (first) begin
        max_idx_d = '0;
        min_idx_d = '0;
      end else begin
        if (gt_max) max_idx_d = count_q;
        if (lt_min) min_idx_d = count_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else begin
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
    end
  end

  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_maxmin_stream.sv
// Directed scoreboard bench for maxmin_stream over three configurations:
// (FRAME_LEN 4, unsigned), (FRAME_LEN 2, signed), (FRAME_LEN 1, unsigned).
module tb_maxmin_stream;

  localparam int FL [3] = '{4, 2, 1};
  localparam bit SG [3] = '{1'b0, 1'b1, 1'b0};

  typedef struct {
    logic [7:0] mx;
    logic [7:0] mn;
    int         cnt;
    int         mxi;
    int         mni;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       vld  [3];
  logic       lst  [3];
  logic       ordy [3];
  logic [7:0] dat  [3];
  logic       irdy [3];
  logic       ovld [3];
  logic [7:0] omax [3];
  logic [7:0] omin [3];
  logic [7:0] ocnt [3];
  logic [7:0] omxi [3];
  logic [7:0] omni [3];
  logic [2:0] cnt_a;
  logic [1:0] cnt_b;
  logic [0:0] cnt_c;

  exp_t       sb [$];
  int         total;
  int         passes;
  logic [7:0] m_max [3];
  logic [7:0] m_min [3];
  int         m_cnt [3];
  int         m_mxi [3];
  int         m_mni [3];

  assign ocnt[0] = {5'b0, cnt_a};
  assign ocnt[1] = {6'b0, cnt_b};
  assign ocnt[2] = {7'b0, cnt_c};

`ifdef MAXMIN_INDEX_EN
  logic [2:0] mxi_a, mni_a;
  logic [1:0] mxi_b, mni_b;
  logic [0:0] mxi_c, mni_c;
  assign omxi[0] = {5'b0, mxi_a};
  assign omni[0] = {5'b0, mni_a};
  assign omxi[1] = {6'b0, mxi_b};
  assign omni[1] = {6'b0, mni_b};
  assign omxi[2] = {7'b0, mxi_c};
  assign omni[2] = {7'b0, mni_c};
`else
  assign omxi[0] = 8'd0;
  assign omni[0] = 8'd0;
  assign omxi[1] = 8'd0;
  assign omni[1] = 8'd0;
  assign omxi[2] = 8'd0;
  assign omni[2] = 8'd0;
`endif

  maxmin_stream #(.WIDTH(8), .FRAME_LEN(4), .SIGNED(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(irdy[0]), .in_data(dat[0]),
    .in_last(lst[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .out_max(omax[0]),
    .out_min(omin[0]), .out_count(cnt_a)
`ifdef MAXMIN_INDEX_EN
    , .out_max_idx(mxi_a), .out_min_idx(mni_a)
`endif
  );

  maxmin_stream #(.WIDTH(8), .FRAME_LEN(2), .SIGNED(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(irdy[1]), .in_data(dat[1]),
    .in_last(lst[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .out_max(omax[1]),
    .out_min(omin[1]), .out_count(cnt_b)
`ifdef MAXMIN_INDEX_EN
    , .out_max_idx(mxi_b), .out_min_idx(mni_b)
`endif
  );

  maxmin_stream #(.WIDTH(8), .FRAME_LEN(1), .SIGNED(1'b0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(irdy[2]), .in_data(dat[2]),
    .in_last(lst[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .out_max(omax[2]),
    .out_min(omin[2]), .out_count(cnt_c)
`ifdef MAXMIN_INDEX_EN
    , .out_max_idx(mxi_c), .out_min_idx(mni_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit greater(input int k, input logic [7:0] a, input logic [7:0] b);
    if (SG[k]) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Reference model: tracks the frame and pushes the expected result when it closes.
  task automatic model(input int k, input logic [7:0] d, input bit last);
    exp_t e;
    if (m_cnt[k] == 0) begin
      m_max[k] = d;
      m_min[k] = d;
      m_mxi[k] = 0;
      m_mni[k] = 0;
    end else begin
      if (greater(k, d, m_max[k])) begin
        m_max[k] = d;
        m_mxi[k] = m_cnt[k];
      end
      if (greater(k, m_min[k], d)) begin
        m_min[k] = d;
        m_mni[k] = m_cnt[k];
      end
    end
    m_cnt[k]++;
    if (last || m_cnt[k] == FL[k]) begin
      e = '{mx: m_max[k], mn: m_min[k], cnt: m_cnt[k], mxi: m_mxi[k], mni: m_mni[k]};
      sb.push_back(e);
      m_cnt[k] = 0;
    end
  endtask

  task automatic send(input int k, input logic [7:0] d, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    vld[k] = 1'b1;
    dat[k] = d;
    lst[k] = last;
    while (!irdy[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", 32'(irdy[k]), 32'd1);
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
    lst[k] = 1'b0;
    model(k, d, last);
  endtask

  task automatic pop_compare(input int k);
    exp_t e;
    check("out_valid", 32'(ovld[k]), 32'd1);
    check("sb_pending", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("out_max", 32'(omax[k]), 32'(e.mx));
      check("out_min", 32'(omin[k]), 32'(e.mn));
      check("out_count", 32'(ocnt[k]), 32'(e.cnt));
`ifdef MAXMIN_INDEX_EN
      check("out_max_idx", 32'(omxi[k]), 32'(e.mxi));
      check("out_min_idx", 32'(omni[k]), 32'(e.mni));
`endif
    end
  endtask

  task automatic collect(input int k);
    int n;
    n = 0;
    while (!ovld[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    pop_compare(k);
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
    check("after_ack_out_valid", 32'(ovld[k]), 32'd0);
    check("after_ack_in_ready", 32'(irdy[k]), 32'd1);
  endtask

  initial begin
    total  = 0;
    passes = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vld[k]   = 1'b0;
      lst[k]   = 1'b0;
      ordy[k]  = 1'b0;
      dat[k]   = 8'h00;
      m_cnt[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", 32'(ovld[k]), 32'd0);
      check("rst_in_ready", 32'(irdy[k]), 32'd1);
      check("rst_out_max", 32'(omax[k]), 32'd0);
      check("rst_out_min", 32'(omin[k]), 32'd0);
      check("rst_out_count", 32'(ocnt[k]), 32'd0);
      check("rst_max_idx", 32'(omxi[k]), 32'd0);
    end
    rst_n = 1'b1;

    // Two-sample frames on the unsigned instance, closed by in_last.
    send(0, 8'd30, 1'b0); send(0, 8'd20, 1'b1); collect(0);
    send(0, 8'd20, 1'b0); send(0, 8'd30, 1'b1); collect(0);
    send(0, 8'd25, 1'b0); send(0, 8'd35, 1'b1); collect(0);
    send(0, 8'hF6, 1'b0); send(0, 8'h05, 1'b1); collect(0);

    // Signed instance, frames closed by FRAME_LEN.
    send(1, 8'hF6, 1'b0); send(1, 8'h05, 1'b0); collect(1);
    send(1, 8'h80, 1'b0); send(1, 8'h7F, 1'b0); collect(1);
    send(1, 8'd30, 1'b0); send(1, 8'd20, 1'b0); collect(1);

    // Early close.
    send(0, 8'd7, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd9, 1'b1); collect(0);

    // in_last on the FRAME_LEN-th sample: one result, no empty frame after it.
    send(0, 8'd1, 1'b0); send(0, 8'd9, 1'b0); send(0, 8'd9, 1'b0); send(0, 8'd1, 1'b1);
    collect(0);
    repeat (3) begin
      @(negedge clk);
      check("no_extra_frame", 32'(ovld[0]), 32'd0);
    end

    // Ties plus backpressure; the sample offered during HOLD must not be taken.
    send(0, 8'd5, 1'b0); send(0, 8'd5, 1'b0); send(0, 8'd5, 1'b0); send(0, 8'd5, 1'b0);
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 8'd99;
    repeat (5) begin
      check("hold_out_valid", 32'(ovld[0]), 32'd1);
      check("hold_in_ready", 32'(irdy[0]), 32'd0);
      check("hold_out_max", 32'(omax[0]), 32'd5);
      check("hold_out_min", 32'(omin[0]), 32'd5);
      check("hold_out_count", 32'(ocnt[0]), 32'd4);
      @(negedge clk);
    end
    vld[0] = 1'b0;
    collect(0);

    // Reset mid-frame discards the partial frame; samples during reset are ignored.
    send(0, 8'd50, 1'b0); send(0, 8'd60, 1'b0);
    @(negedge clk);
    rst_n  = 1'b0;
    vld[0] = 1'b1;
    dat[0] = 8'd77;
    #1;
    check("midrst_out_max", 32'(omax[0]), 32'd0);
    check("midrst_out_min", 32'(omin[0]), 32'd0);
    check("midrst_out_count", 32'(ocnt[0]), 32'd0);
    check("midrst_in_ready", 32'(irdy[0]), 32'd1);
    check("midrst_out_valid", 32'(ovld[0]), 32'd0);
    @(negedge clk);
    vld[0]   = 1'b0;
    rst_n    = 1'b1;
    m_cnt[0] = 0;
    send(0, 8'd1, 1'b0); send(0, 8'd2, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd4, 1'b0);
    collect(0);

    // FRAME_LEN=1 back-to-back with out_ready held high: one bubble between acceptances.
    ordy[2] = 1'b1;
    @(negedge clk);
    vld[2] = 1'b1;
    dat[2] = 8'd10;
    check("b2b_first_ready", 32'(irdy[2]), 32'd1);
    model(2, 8'd10, 1'b0);
    @(negedge clk);
    pop_compare(2);
    check("b2b_hold_ready", 32'(irdy[2]), 32'd0);
    dat[2] = 8'd200;
    @(negedge clk);
    check("b2b_bubble_valid", 32'(ovld[2]), 32'd0);
    check("b2b_bubble_ready", 32'(irdy[2]), 32'd1);
    model(2, 8'd200, 1'b0);
    @(negedge clk);
    pop_compare(2);
    vld[2] = 1'b0;
    @(negedge clk);
    check("b2b_end_valid", 32'(ovld[2]), 32'd0);
    ordy[2] = 1'b0;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/maxmin_stream.md
# maxmin_stream

Streaming, parameterised successor to the two-operand max/min comparator. Accepts a valid/ready stream of WIDTH-bit samples, tracks running maximum and minimum over a frame of up to FRAME_LEN samples (or until `in_last`), then presents the frame result on a valid/ready output port. Sits between a sample source and any consumer needing per-frame extrema, such as range detection or normalisation.

## Interface
- `WIDTH`, 8: sample width in bits (>= 2).
- `FRAME_LEN`, 16: maximum samples per frame (>= 1).
- `SIGNED`, 0: 0 = unsigned compare; 1 = two's-complement compare.
- Derived: `CW = $clog2(FRAME_LEN+1)`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: sample present.
- `in_ready` out 1: block can accept a sample.
- `in_data` in WIDTH: sample.
- `in_last` in 1: sample closes the frame early; qualified by the input handshake.
- `out_valid` out 1: frame result available.
- `out_ready` in 1: consumer takes the result.
- `out_max` out WIDTH: frame maximum.
- `out_min` out WIDTH: frame minimum.
- `out_count` out CW: samples in the frame (1..FRAME_LEN).
- `out_max_idx`, `out_min_idx` out CW: 0-based position of the extremum in the frame. Present only with `MAXMIN_INDEX_EN`.

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- `in_ready = (state == ACCUM)`. `out_valid = (state == HOLD)`.
- Input handshake is `in_valid && in_ready`.
- First accepted sample of a frame loads both max and min, and sets count to 1.
- Each later accepted sample:
  - updates max when the sample is strictly greater;
  - updates min when the sample is strictly less;
  - increments count.
- Ties keep the earlier sample, so the earliest index wins.
- The frame closes on the accepted sample that has `in_last=1` or that makes count equal FRAME_LEN; then go to HOLD.
- `in_last` with FRAME_LEN not yet reached gives a short frame. `in_last` on the FRAME_LEN-th sample gives a single close, not an extra empty frame.
- HOLD:
  - `out_max`, `out_min`, `out_count` and the index outputs are stable.
  - On `out_ready`, go to ACCUM with count cleared.
- `out_valid` never drops without a handshake. Empty frames are never emitted.
- Comparison is WIDTH-bit and lossless, with no overflow paths.
  - SIGNED=1: MSB is the sign bit, e.g. 8'h80 < 8'h7F.
  - SIGNED=0: plain magnitude.
- In ACCUM, result outputs show the running accumulators and are meaningful only when `out_valid=1`.

## Timing
- Reset (asynchronous on `rst_n` low): state ACCUM, `out_valid=0`, `out_max=0`, `out_min=0`, `out_count=0`, index outputs 0, `in_ready=1`. Samples presented while `rst_n` is low are ignored.
- Reset mid-frame or during HOLD discards the partial or pending result. There is no output handshake after release.
- Latency: `out_valid` rises on the first edge after the closing sample is accepted.
- If `out_ready=1` in the first HOLD cycle, `in_ready` is high again the next cycle. Minimum cost is one bubble cycle per frame.
- `in_valid` held during HOLD is not accepted. The source must keep the sample until `in_ready`.
- FRAME_LEN=1: every accepted sample produces a result with max = min = sample, count 1.
- `in_valid` low cycles within a frame do not change state.

## Configuration
- `MAXMIN_INDEX_EN` defined:
  - `out_max_idx` and `out_min_idx` exist.
  - Both are loaded with the current count-before-increment on the respective update, and with 0 on the first sample.
  - Both reset to 0.
- Macro undefined: both ports and their registers are absent. All other behaviour is identical.

## Structure
- Package `maxmin_pkg`:
  - state enum (ACCUM, HOLD);
  - `CW` helper function.
- Sub-module `maxmin_cmp` (combinational):
  - parameters WIDTH and SIGNED;
  - inputs a and b;
  - outputs `gt` (a>b) and `lt` (a<b).
- Two instances: sample vs max, sample vs min.
- Top holds the FSM, accumulators, counter and handshake logic.

## Test plan
- Basic unsigned: WIDTH=8, SIGNED=0, FRAME_LEN=2, samples 30, 20 → max 30, min 20, count 2. Samples 20, 30 → same. Samples 25, 35 → max 35, min 25.
- Signed vs unsigned: samples 8'hF6, 8'h05.
  - SIGNED=1 → max 05, min F6.
  - SIGNED=0 → max F6, min 05.
- Early close: FRAME_LEN=16, samples 7, 3, 9 with `in_last` on 9 → max 9, min 3, count 3. Index build → `max_idx` 2, `min_idx` 1.
- Ties and backpressure: samples 5, 5, 5, 5 at FRAME_LEN=4, with `out_ready` held low 5 cycles.
  - `out_valid` stays high and outputs stay stable.
  - `in_ready` stays 0 and a presented sample is not consumed.
  - `max_idx` = `min_idx` = 0.
- Reset mid-frame: 2 of 4 samples accepted, then `rst_n` pulse → outputs 0, `in_ready=1`. A new 4-sample frame of 1, 2, 3, 4 → max 4, min 1, count 4.
- FRAME_LEN=1 back-to-back: samples 10, 200 with `out_ready=1` → two results, (10, 10) then (200, 200), with one bubble cycle between acceptances.
